// File: rtl/branch_exec_queue.sv
// branch_exec_queue
// Branch/jump execution unit with an in-order result queue feeding the CDB.
// An accepted issue is resolved combinationally (direction, target, link
// value, misprediction) and the finished result is stored at the queue tail.
// The head entry is presented on out_* until the CDB arbiter grants it.
//
// Handshake semantics (single place): an issue transfers on a rising edge
// when in_valid && in_ready && rdy_in; a result transfers on a rising edge
// when out_valid && cdb_grant && rdy_in. in_ready/out_valid never depend on
// in_valid/cdb_grant, so no combinational loop exists through either side.
//
// Optional feature macro: BRANCH_STATS_EN enables the 32-bit branch and
// misprediction event counters; without it the stat ports read constant 0.
module branch_exec_queue #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int OP_W  = 6,
    parameter int DEPTH = 4,
    // Opcode encodings of the branch/jump class
    parameter logic [OP_W-1:0] OP_JAL  = OP_W'(1),
    parameter logic [OP_W-1:0] OP_JALR = OP_W'(2),
    parameter logic [OP_W-1:0] OP_BEQ  = OP_W'(3),
    parameter logic [OP_W-1:0] OP_BNE  = OP_W'(4),
    parameter logic [OP_W-1:0] OP_BLT  = OP_W'(5),
    parameter logic [OP_W-1:0] OP_BGE  = OP_W'(6),
    parameter logic [OP_W-1:0] OP_BLTU = OP_W'(7),
    parameter logic [OP_W-1:0] OP_BGEU = OP_W'(8)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [XLEN-1:0]  in_reg1,
    input  logic [XLEN-1:0]  in_reg2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             cdb_grant,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_jump,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_orig_pc,
    output logic [XLEN-1:0]  out_data,
    output logic             out_mispredict,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             jump;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  orig_pc;
        logic [XLEN-1:0]  data;
        logic             mispredict;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_known;
    logic             w_jump;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_data;
    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_pc_imm;
    logic [XLEN-1:0]  w_reg_imm;
    entry_t           w_entry;
    entry_t           w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;

    assign w_pc_plus4 = in_pc + XLEN'(4);
    assign w_pc_imm   = in_pc + in_imm;
    assign w_reg_imm  = in_reg1 + in_imm;

    // Resolve the incoming branch/jump: direction, target and link value
    always_comb begin
        w_known  = 1'b1;
        w_jump   = 1'b0;
        w_target = w_pc_imm;
        w_data   = '0;
        case (in_op)
            OP_BEQ:  w_jump = (in_reg1 == in_reg2);
            OP_BNE:  w_jump = (in_reg1 != in_reg2);
            OP_BLT:  w_jump = ($signed(in_reg1) < $signed(in_reg2));
            OP_BGE:  w_jump = ($signed(in_reg1) >= $signed(in_reg2));
            OP_BLTU: w_jump = (in_reg1 < in_reg2);
            OP_BGEU: w_jump = (in_reg1 >= in_reg2);
            OP_JAL: begin
                w_jump = 1'b1;
                w_data = w_pc_plus4;
            end
            OP_JALR: begin
                w_jump   = 1'b1;
                w_target = {w_reg_imm[XLEN-1:1], 1'b0};
                w_data   = w_pc_plus4;
            end
            default: w_known = 1'b0;
        endcase
    end

    // Assemble the finished result that gets written at the tail
    always_comb begin
        w_entry.tag        = in_tag;
        w_entry.jump       = w_jump;
        w_entry.pc         = w_jump ? w_target : w_pc_plus4;
        w_entry.orig_pc    = in_pc;
        w_entry.data       = w_data;
        w_entry.mispredict = (w_jump != in_pred_taken) ||
                             (w_jump && (w_target != in_pred_pc));
    end

    // Ready is withheld during reset and during a flush cycle
    assign in_ready  = !rst_in && !flush && (r_count < CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_flush   = flush && rdy_in;
    // Unknown opcodes complete the handshake but never occupy an entry
    assign w_push    = in_valid && in_ready && rdy_in && w_known;
    assign w_pop     = out_valid && cdb_grant && rdy_in && !flush;

    // Pointer and occupancy bookkeeping; flush wins over push and pop
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Result storage; contents are only observed while counted as occupied
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_tail] <= w_entry;
    end

    assign w_head = r_mem[r_head];

    // Head fields are forced to zero whenever the queue is empty
    always_comb begin
        out_tag        = '0;
        out_jump       = 1'b0;
        out_pc         = '0;
        out_orig_pc    = '0;
        out_data       = '0;
        out_mispredict = 1'b0;
        if (out_valid) begin
            out_tag        = w_head.tag;
            out_jump       = w_head.jump;
            out_pc         = w_head.pc;
            out_orig_pc    = w_head.orig_pc;
            out_data       = w_head.data;
            out_mispredict = w_head.mispredict;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    // Count results that actually leave on the CDB (flushed heads excluded)
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_pop) begin
            r_stat_branches <= r_stat_branches + 32'd1;
            if (w_head.mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: doc/branch_exec_queue.md
BRANCH_EXEC_QUEUE -- requirements
Module: branch_exec_queue

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter XLEN, 32, data/address width.
REQ-003 Parameter TAG_W, 4, ROB tag width.
REQ-004 Parameter OP_W, 6, opcode width; encodings are the cpu_define.v BEQ..JALR macros.
REQ-005 Parameter DEPTH, 4, result-queue entries; power of two, >=2.
REQ-006 clk_in  input  1  clock; all state updates on rising edge.
REQ-007 rst_in  input  1  asynchronous active-high reset.
REQ-008 rdy_in  input  1  global enable; low freezes all state.
REQ-009 in_valid  input  1  issue request from BranchRS.
REQ-010 in_ready  output  1  queue can accept an issue this cycle.
REQ-011 in_op  input  OP_W  branch/jump opcode.
REQ-012 in_reg1, in_reg2, in_imm  input  XLEN each  rs1, rs2, sign-extended immediate.
REQ-013 in_pc  input  XLEN  instruction PC.
REQ-014 in_tag  input  TAG_W  destination ROB tag.
REQ-015 in_pred_taken  input  1  front-end taken prediction.
REQ-016 in_pred_pc  input  XLEN  front-end predicted next PC.
REQ-017 flush  input  1  ROB misprediction clear.
REQ-018 out_valid  output  1  head entry valid on CDB.
REQ-019 cdb_grant  input  1  CDB arbiter accepts head this cycle.
REQ-020 out_tag, out_jump, out_pc, out_orig_pc, out_data, out_mispredict  output  TAG_W/1/XLEN/XLEN/XLEN/1  head result fields.
REQ-021 stat_branches, stat_mispredicts  output  32 each  event counters.

Function
REQ-022 in_ready SHALL be 1 exactly when occupancy < DEPTH and flush is 0.
REQ-023 An issue is accepted on an edge when in_valid, in_ready and rdy_in are all 1; the result is computed combinationally and written to the tail entry.
REQ-024 Latency: issue accepted at edge N, entry visible with out_valid=1 after edge N when the queue was empty.
REQ-025 Conditional ops: jump = BEQ ==, BNE !=, BLT/BGE signed <, >=, BLTU/BGEU unsigned <, >=; target = pc + imm (mod 2^XLEN); data = 0.
REQ-026 JAL: jump=1, target = pc+imm; JALR: jump=1, target = (reg1+imm) & ~1; data = pc+4 for both.
REQ-027 out_pc = target if jump else pc+4; out_orig_pc = in_pc.
REQ-028 out_mispredict = (jump != pred_taken) OR (jump AND target != pred_pc).
REQ-029 Unknown op: issue is accepted and dropped; no entry is written.
REQ-030 Head pops on an edge when out_valid, cdb_grant and rdy_in are all 1; push and pop in the same cycle SHALL both occur, leaving occupancy unchanged.
REQ-031 Pointers SHALL wrap modulo DEPTH; the full and empty conditions SHALL be distinguished using an extra pointer bit or an occupancy counter.
REQ-032 When out_valid=0, all out_* fields other than out_valid SHALL be 0.
REQ-033 flush=1 (with rdy_in=1) empties the queue at the next edge; flush has priority over push and pop; the popped head in that cycle is not counted.
REQ-034 rdy_in=0: no push, pop, flush or counter update; outputs hold.

Reset
REQ-035 rst_in=1: queue empty, out_valid=0, all out_* fields=0, counters=0, in_ready=0 while reset is asserted; reset applies immediately and mid-operation entries are discarded.

Configuration
REQ-036 Macro BRANCH_STATS_EN defined: stat_branches increments on every pop, and stat_mispredicts increments on every pop with out_mispredict=1; both wrap at 2^32.
REQ-037 BRANCH_STATS_EN undefined: stat ports SHALL exist and SHALL be constant 0, and no counter registers are built.

Verification
REQ-038 BEQ, reg1=reg2=5, pc=0x100, imm=0x20, pred_taken=1, pred_pc=0x120 -> one cycle later out_valid=1, out_jump=1, out_pc=0x120, out_mispredict=0.
REQ-039 BLT, reg1=0xFFFFFFFF, reg2=1, pc=0x200, imm=8, pred_taken=0 -> out_jump=1, out_pc=0x208, out_mispredict=1; BLTU with the same operands -> out_jump=0, out_pc=0x204.
REQ-040 JALR, reg1=0x1003, imm=0, pc=0x40 -> out_pc=0x1002, out_data=0x44, out_jump=1.
REQ-041 Issue 4 ops with cdb_grant=0 -> in_ready=0 after the 4th; grant held 1 -> results pop in issue order with tags 1,2,3,4; simultaneous push and pop at full is blocked, while push and pop at occupancy 2 keeps occupancy at 2.
REQ-042 Queue holds 3 entries, assert flush -> next cycle out_valid=0, in_ready=1; reset asserted mid-stream -> outputs 0 immediately.
REQ-043 With BRANCH_STATS_EN, pop 5 results including 2 mispredicts -> stat_branches=5, stat_mispredicts=2; without the macro, both read 0.
